// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and default iteration count.
package muldiv_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER_DEFAULT = 32;

    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for muldiv_unit (combinational).
// Entry side: srca/srcb/uns -> a_abs/b_abs, a_neg/b_neg.
// Exit side: op/sign_a/sign_b/acc_hi/acc_lo -> res_hi/res_lo.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             uns,
    output logic [WIDTH-1:0] a_abs,
    output logic [WIDTH-1:0] b_abs,
    output logic             a_neg,
    output logic             b_neg,
    input  logic             op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_n;

    assign a_neg = srca[WIDTH-1] & ~uns;
    assign b_neg = srcb[WIDTH-1] & ~uns;
    assign a_abs = a_neg ? -srca : srca;
    assign b_abs = b_neg ? -srcb : srcb;

    assign prod   = {acc_hi, acc_lo};
    assign prod_n = -prod;

    // A zero magnitude negates to zero, so the product only
    // comes out negative when both operands are nonzero.
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (op == OP_DIV) begin
            if (sign_a ^ sign_b) res_lo = -acc_lo;
            if (sign_a)          res_hi = -acc_hi;
        end else if (sign_a ^ sign_b) begin
            res_hi = prod_n[2*WIDTH-1:WIDTH];
            res_lo = prod_n[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/div unit owning HI/LO; busy stalls the core.
// Ports: clk, reset, start, op, srca, srcb, wr_hi, wr_lo,
//   wdata -> busy, done, hi, lo.
// MULDIV_UNSIGNED_EN adds is_unsigned (multu/divu).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             op_q, sa_q, sb_q;
    logic             busy_q, done_q;

    logic             uns;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             accept, step, fix;
    logic             div0;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;

`ifdef MULDIV_UNSIGNED_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .srca   (srca),
        .srcb   (srcb),
        .uns    (uns),
        .a_abs  (a_abs),
        .b_abs  (b_abs),
        .a_neg  (a_neg),
        .b_neg  (b_neg),
        .op     (op_q),
        .sign_a (sa_q),
        .sign_b (sb_q),
        .acc_hi (acc_hi_q),
        .acc_lo (acc_lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= fix;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (cnt_q == CW'(ITER - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                fix     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mult: right-shifting shift-add, multiplier in acc_lo.
    // Div: restoring, dividend shifts out of acc_lo into
    // the remainder in acc_hi, quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q}
                 + (acc_lo_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        if (op_q == OP_DIV) begin
            if (!div_diff[WIDTH]) begin
                acc_hi_d = div_diff[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = div_sh[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            op_q     <= OP_MULT;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            a_q      <= a_abs;
            b_q      <= b_abs;
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            op_q     <= op;
            acc_hi_q <= '0;
            acc_lo_q <= (op == OP_DIV) ? a_abs : b_abs;
        end else if (step) begin
            cnt_q    <= cnt_q + CW'(1);
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    // With a zero divisor the restoring loop already leaves
    // |srca| as remainder, so only lo needs overriding.
    assign div0 = (op_q == OP_DIV) && (b_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix) begin
            hi_q <= res_hi;
            lo_q <= div0 ? WIDTH'(DIV0_LO) : res_lo;
        end else if (state_q == S_IDLE) begin
            if (wr_hi) hi_q <= wdata;
            if (wr_lo) lo_q <= wdata;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
